invaders_load_ctrl: RTL and testbench

Sequences the HPS ioctl download stream into the invaders core's memories and configuration registers. It routes each byte to the CPU ROM, colour PROM, machine-select byte or DIP-switch bank, and owns the core reset. The reset is held through any ROM/PROM load and for a fixed settle period afterwards. It sits between hps_io and invaders_top, replacing ad-hoc ioctl decoding in the top level.

---
 rtl/invaders_load_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_invaders_load_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invaders_load_ctrl.sv
// invaders_load_ctrl
//
// Steers the hps_io ioctl download stream into the invaders core: CPU ROM
// bytes, colour PROM bytes, the machine-select byte and the 64-bit DIP bank.
// It also owns the core reset, which is held during any ROM/PROM download
// and for HOLD_CYCLES clk_sys cycles after it (and after reset_n or
// user_reset).
//
// Handshake: there is no backpressure. A byte is accepted on any cycle where
// ioctl_download=1 and ioctl_wr=1. ROM/PROM writes come out as single-cycle
// rom_wr/prom_wr pulses one cycle later. Their addr/din outputs hold their
// last value between pulses.
//
// Ports
//   clk_sys        sole clock, rising edge
//   reset_n        synchronous active-low reset
//   ioctl_download download window
//   ioctl_wr       byte strobe
//   ioctl_addr     byte address within the current download
//   ioctl_dout     byte data
//   ioctl_index    0 CPU ROM, 1 machine select, 2 colour PROM, 254 DIP bank
//   user_reset     level reset request
//   rom_wr/rom_addr/rom_din     CPU ROM write port
//   prom_wr/prom_addr/prom_din  colour PROM write port
//   mod            machine-select byte
//   dip            DIP bank; byte n is dip[8n+7:8n]
//   core_reset     active-high reset to invaders_top
//   load_err       sticky out-of-range write flag, cleared on LOAD entry
module invaders_load_ctrl #(
  parameter int ROM_AW      = 16,
  parameter int PROM_AW     = 10,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [7:0]         ioctl_index,
  input  logic               user_reset,
  output logic               rom_wr,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [7:0]         rom_din,
  output logic               prom_wr,
  output logic [PROM_AW-1:0] prom_addr,
  output logic [7:0]         prom_din,
  output logic [7:0]         mod,
  output logic [63:0]        dip,
  output logic               core_reset,
  output logic               load_err
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MOD  = 8'd1;
  localparam logic [7:0] IDX_PROM = 8'd2;
  localparam logic [7:0] IDX_DIP  = 8'd254;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // FSM state is kept as a named enum so checkers can bind to it directly.
  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic load_start;
  logic load_entry;
  logic wr_strobe;
  logic rom_in_range;
  logic prom_in_range;
  logic rom_hit;
  logic prom_hit;
  logic wr_err;

  // DIP downloads never count as a load start: they update live.
  assign load_start    = ioctl_download && (ioctl_index != IDX_DIP);
  assign load_entry    = load_start && (state != S_LOAD);
  assign wr_strobe     = ioctl_download && ioctl_wr;
  assign rom_in_range  = (ioctl_addr >> ROM_AW) == 25'd0;
  assign prom_in_range = (ioctl_addr >> PROM_AW) == 25'd0;
  assign rom_hit       = wr_strobe && (ioctl_index == IDX_ROM);
  assign prom_hit      = wr_strobe && (ioctl_index == IDX_PROM);
  assign wr_err        = (rom_hit && !rom_in_range) || (prom_hit && !prom_in_range);

  // Reset sequencer. core_reset is registered alongside the state and is
  // 1 in every branch whose next state is not RUN.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= S_HOLD;
      cnt        <= '0;
      core_reset <= 1'b1;
    end else begin
      case (state)
        S_HOLD: begin
          if (load_start) begin
            state      <= S_LOAD;
            core_reset <= 1'b1;
          end else if (user_reset) begin
            cnt        <= '0;
            core_reset <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            core_reset <= 1'b1;
          end
        end
        S_RUN: begin
          if (load_start) begin
            state      <= S_LOAD;
            core_reset <= 1'b1;
          end else if (user_reset) begin
            state      <= S_HOLD;
            cnt        <= '0;
            core_reset <= 1'b1;
          end else begin
            core_reset <= 1'b0;
          end
        end
        S_LOAD: begin
          // user_reset and index changes are ignored while loading.
          if (!ioctl_download) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
          core_reset <= 1'b1;
        end
        default: begin
          state      <= S_HOLD;
          cnt        <= '0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

  // Write decode, independent of the sequencer state.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rom_wr    <= 1'b0;
      rom_addr  <= '0;
      rom_din   <= '0;
      prom_wr   <= 1'b0;
      prom_addr <= '0;
      prom_din  <= '0;
      mod       <= '0;
      dip       <= '0;
      load_err  <= 1'b0;
    end else begin
      rom_wr  <= rom_hit && rom_in_range;
      prom_wr <= prom_hit && prom_in_range;

      if (rom_hit && rom_in_range) begin
        rom_addr <= ioctl_addr[ROM_AW-1:0];
        rom_din  <= ioctl_dout;
      end

      if (prom_hit && prom_in_range) begin
        prom_addr <= ioctl_addr[PROM_AW-1:0];
        prom_din  <= ioctl_dout;
      end

      if (wr_strobe && (ioctl_index == IDX_MOD) && (ioctl_addr == 25'd0)) begin
        mod <= ioctl_dout;
      end

      if (wr_strobe && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0)) begin
        dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end

      // A bad write in the entry cycle must still leave the flag set.
      if (wr_err) begin
        load_err <= 1'b1;
      end else if (load_entry) begin
        load_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_invaders_load_ctrl.sv
module tb_invaders_load_ctrl;

  localparam int ROM_AW  = 16;
  localparam int PROM_AW = 10;
  localparam int HOLD    = 16;

  // ---------------- clock / reset / DUT ----------------
  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic               ioctl_download;
  logic               ioctl_wr;
  logic [24:0]        ioctl_addr;
  logic [7:0]         ioctl_dout;
  logic [7:0]         ioctl_index;
  logic               user_reset;
  logic               rom_wr;
  logic [ROM_AW-1:0]  rom_addr;
  logic [7:0]         rom_din;
  logic               prom_wr;
  logic [PROM_AW-1:0] prom_addr;
  logic [7:0]         prom_din;
  logic [7:0]         mod;
  logic [63:0]        dip;
  logic               core_reset;
  logic               load_err;

  always #5 clk_sys = ~clk_sys;

  invaders_load_ctrl #(
    .ROM_AW      (ROM_AW),
    .PROM_AW     (PROM_AW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .user_reset     (user_reset),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_din        (rom_din),
    .prom_wr        (prom_wr),
    .prom_addr      (prom_addr),
    .prom_din       (prom_din),
    .mod            (mod),
    .dip            (dip),
    .core_reset     (core_reset),
    .load_err       (load_err)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [ROM_AW+7:0]  rom_q[$];
  logic [PROM_AW+7:0] prom_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Reset release is tracked as an absolute edge number: core_reset is
  // expected high while a load is open or until release_at is reached.
  bit                 model_valid = 1'b0;
  int                 edge_n      = 0;
  int                 release_at  = 0;
  bit                 loading     = 1'b0;
  logic               exp_rom_wr, exp_prom_wr, exp_err, exp_core_reset;
  logic [ROM_AW-1:0]  exp_rom_addr;
  logic [PROM_AW-1:0] exp_prom_addr;
  logic [7:0]         exp_rom_din, exp_prom_din, exp_mod;
  logic [63:0]        exp_dip;

  always @(posedge clk_sys) begin : model
    bit ls, entry, err;
    int a;
    ls = ioctl_download && (ioctl_index != 8'd254);
    edge_n++;
    if (!reset_n) begin
      model_valid   = 1'b1;
      loading       = 1'b0;
      release_at    = edge_n + HOLD;
      exp_rom_wr    = 1'b0;
      exp_prom_wr   = 1'b0;
      exp_rom_addr  = '0;
      exp_rom_din   = '0;
      exp_prom_addr = '0;
      exp_prom_din  = '0;
      exp_mod       = '0;
      exp_dip       = '0;
      exp_err       = 1'b0;
      rom_q.delete();
      prom_q.delete();
    end else begin
      entry       = ls && !loading;
      err         = 1'b0;
      exp_rom_wr  = 1'b0;
      exp_prom_wr = 1'b0;
      if (ioctl_download && ioctl_wr) begin
        a = int'(ioctl_addr);
        case (ioctl_index)
          8'd0: begin
            if (a < (1 << ROM_AW)) begin
              exp_rom_wr   = 1'b1;
              exp_rom_addr = ioctl_addr[ROM_AW-1:0];
              exp_rom_din  = ioctl_dout;
              rom_q.push_back({exp_rom_addr, exp_rom_din});
            end else begin
              err = 1'b1;
            end
          end
          8'd2: begin
            if (a < (1 << PROM_AW)) begin
              exp_prom_wr   = 1'b1;
              exp_prom_addr = ioctl_addr[PROM_AW-1:0];
              exp_prom_din  = ioctl_dout;
              prom_q.push_back({exp_prom_addr, exp_prom_din});
            end else begin
              err = 1'b1;
            end
          end
          8'd1:   if (a == 0) exp_mod = ioctl_dout;
          8'd254: if (a < 8) exp_dip[a*8 +: 8] = ioctl_dout;
          default: ;
        endcase
      end
      if (err) exp_err = 1'b1;
      else if (entry) exp_err = 1'b0;

      if (loading) begin
        if (!ioctl_download) begin
          loading    = 1'b0;
          release_at = edge_n + HOLD;
        end
      end else if (ls) begin
        loading = 1'b1;
      end else if (user_reset) begin
        release_at = edge_n + HOLD;
      end
    end
    exp_core_reset = loading || (edge_n < release_at);
  end

  // ---------------- monitor ----------------
  always @(negedge clk_sys) begin : monitor
    logic [ROM_AW+7:0]  re;
    logic [PROM_AW+7:0] pe;
    if (model_valid) begin
      chk("core_reset", 64'(core_reset), 64'(exp_core_reset));
      chk("load_err",   64'(load_err),   64'(exp_err));
      chk("rom_wr",     64'(rom_wr),     64'(exp_rom_wr));
      chk("rom_addr",   64'(rom_addr),   64'(exp_rom_addr));
      chk("rom_din",    64'(rom_din),    64'(exp_rom_din));
      chk("prom_wr",    64'(prom_wr),    64'(exp_prom_wr));
      chk("prom_addr",  64'(prom_addr),  64'(exp_prom_addr));
      chk("prom_din",   64'(prom_din),   64'(exp_prom_din));
      chk("mod",        64'(mod),        64'(exp_mod));
      chk("dip",        dip,             exp_dip);
      if (rom_wr === 1'b1) begin
        chk("rom_q_has_entry", 64'(rom_q.size() != 0), 64'd1);
        if (rom_q.size() != 0) begin
          re = rom_q.pop_front();
          chk("rom_q_addr_data", 64'({rom_addr, rom_din}), 64'(re));
        end
      end
      if (prom_wr === 1'b1) begin
        chk("prom_q_has_entry", 64'(prom_q.size() != 0), 64'd1);
        if (prom_q.size() != 0) begin
          pe = prom_q.pop_front();
          chk("prom_q_addr_data", 64'({prom_addr, prom_din}), 64'(pe));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    ioctl_addr     = a;
    ioctl_dout     = d;
    ioctl_wr       = 1'b1;
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
  endtask

  task automatic rand_download();
    int          r, n;
    logic [7:0]  idx;
    logic [24:0] a;
    r = $urandom_range(0, 9);
    if (r <= 3)      idx = 8'd0;
    else if (r == 4) idx = 8'd1;
    else if (r <= 6) idx = 8'd2;
    else if (r <= 8) idx = 8'd254;
    else             idx = 8'($urandom_range(3, 253));
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) idx = 8'($urandom_range(0, 3));
      case (idx)
        8'd0:    a = ($urandom_range(0, 5) == 0) ? 25'(32'h10000 + $urandom_range(0, 32'hFFFF))
                                                 : 25'($urandom_range(0, 32'hFFFF));
        8'd2:    a = 25'($urandom_range(0, 32'h7FF));
        8'd1:    a = 25'($urandom_range(0, 2));
        8'd254:  a = 25'($urandom_range(0, 9));
        default: a = 25'($urandom_range(0, 32'hFF));
      endcase
      user_reset = ($urandom_range(0, 15) == 0);
      send_byte(idx, a, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    end_dl();
    user_reset = ($urandom_range(0, 7) == 0);
    @(negedge clk_sys);
    user_reset = 1'b0;
    idle($urandom_range(0, 24));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    user_reset     = 1'b0;

    // Power-up: reset low for three edges.
    idle(3);
    reset_n = 1'b1;
    idle(20);

    // ROM load, back-to-back bytes.
    send_byte(8'd0, 25'd0, 8'hC3);
    send_byte(8'd0, 25'd1, 8'h00);
    send_byte(8'd0, 25'd2, 8'h18);
    end_dl();
    idle(20);

    // Out-of-range ROM byte, then a PROM download that clears the flag.
    send_byte(8'd0, 25'h10000, 8'h55);
    end_dl();
    idle(2);
    send_byte(8'd2, 25'h3FF, 8'h07);
    end_dl();
    idle(20);

    // Machine select, then live DIP updates while running.
    send_byte(8'd1, 25'd0, 8'h0A);
    end_dl();
    idle(20);
    send_byte(8'd254, 25'd0, 8'h11);
    send_byte(8'd254, 25'd1, 8'h22);
    send_byte(8'd254, 25'd2, 8'h33);
    send_byte(8'd254, 25'd8, 8'h99);
    end_dl();
    idle(3);

    // One-cycle user_reset in RUN.
    user_reset = 1'b1;
    @(negedge clk_sys);
    user_reset = 1'b0;
    idle(20);

    // user_reset held through a ROM load.
    user_reset = 1'b1;
    send_byte(8'd0, 25'd5, 8'hAA);
    send_byte(8'd0, 25'd6, 8'hBB);
    idle(1);
    end_dl();
    user_reset = 1'b0;
    idle(20);

    // reset_n on a strobe cycle in the middle of a ROM load.
    send_byte(8'd0, 25'd10, 8'h11);
    ioctl_addr = 25'd11;
    ioctl_dout = 8'h22;
    ioctl_wr   = 1'b1;
    reset_n    = 1'b0;
    @(negedge clk_sys);
    reset_n    = 1'b1;
    ioctl_wr   = 1'b0;
    idle(2);
    end_dl();
    idle(20);

    // Randomized downloads with occasional resets.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
      end
      rand_download();
    end
    idle(20);

    chk("rom_q_drained",  64'(rom_q.size()),  64'd0);
    chk("prom_q_drained", 64'(prom_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
